// File: rtl/xor_lfsr_descrambler_pkg.sv
// Shared definitions for the x^7 + x^6 + 1 self-synchronising descrambler:
// training state encoding, default polynomial shape and error counter limits.
package xor_lfsr_descrambler_pkg;

  // Default polynomial x^7 + x^6 + 1: register length and inner tap (1-based).
  localparam int DEF_WIDTH      = 7;
  localparam int DEF_TAP        = 6;
  localparam int DEF_LOCK_COUNT = 16;

  // Training error counter width and the value it sticks at.
  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = 8'd255;

  // Link training progress.
  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,  // filling the shift register with line bits
    ST_TRAIN  = 2'd1,  // counting consecutive descrambled zeros
    ST_LOCKED = 2'd2   // payload passes through unchecked
  } state_e;

  // Increment that stops at ERR_CNT_SAT instead of wrapping to zero.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/xor_lfsr_descrambler_shift_reg_n.sv
// Serial-in / parallel-out shift register with enable and asynchronous
// active-low clear, in the style of a 74x164. q_o[0] holds the newest bit
// and older bits move toward q_o[W-1].
module shift_reg_n #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q;

  // Shift one place toward the MSB when enabled; the clear empties the line history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
      sr_q <= {sr_q[W-2:0], d_i};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/xor_lfsr_descrambler.sv
// Self-synchronising serial descrambler for x^7 + x^6 + 1. The line bit is
// XORed with two taps of the received-bit history, so the descrambler
// realigns with the far-end scrambler after WIDTH bits regardless of its
// starting contents. A small training FSM then counts descrambled zeros to
// declare lock and counts training errors (saturating).
module xor_lfsr_descrambler
  import xor_lfsr_descrambler_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TAP        = DEF_TAP,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_i,
  input  logic                 din_valid_i,
  input  logic                 resync_i,
  output logic                 dout_o,
  output logic                 dout_valid_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int FLUSH_W = $clog2(WIDTH + 1);
  localparam int ZERO_W  = 8;

  // Terminal values: the flush ends on the WIDTH-th valid bit, lock is
  // declared on the LOCK_COUNT-th consecutive zero.
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(WIDTH - 1);
  localparam logic [ZERO_W-1:0]  ZERO_LAST  = ZERO_W'(LOCK_COUNT - 1);

  // Received-bit history; sr[k-1] is SR[k] with SR[1] the newest bit.
  logic [WIDTH-1:0] sr;

  shift_reg_n #(
    .W (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (din_valid_i),
    .d_i   (din_i),
    .q_o   (sr)
  );

  state_e               state_q,      state_d;
  logic [FLUSH_W-1:0]   flush_cnt_q,  flush_cnt_d;
  logic [ZERO_W-1:0]    zero_cnt_q,   zero_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic                 locked_q,     locked_d;
  logic                 dout_q,       dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 desc_bit;

  // Undo the scrambler using the history as it stood before this bit shifts in.
  always_comb begin
    desc_bit = din_i ^ sr[TAP-1] ^ sr[WIDTH-1];
  end

  // Next-state logic for training, counters and the registered outputs.
  always_comb begin
    // NOTE: every target gets a hold value first, so no path can infer a latch.
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    zero_cnt_d   = zero_cnt_q;
    err_cnt_d    = err_cnt_q;
    locked_d     = locked_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    // Every valid bit is descrambled, whatever the training state or RESYNC.
    if (din_valid_i) begin
      dout_d       = desc_bit;
      dout_valid_d = 1'b1;
    end

    if (resync_i) begin
      // Restart training; a bit arriving with RESYNC is not part of the new flush.
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      zero_cnt_d  = '0;
      locked_d    = 1'b0;
    end else if (din_valid_i) begin
      unique case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = ST_TRAIN;
            flush_cnt_d = '0;
            zero_cnt_d  = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        ST_TRAIN: begin
          if (desc_bit) begin
            zero_cnt_d = '0;
            err_cnt_d  = sat_inc(err_cnt_q);
          end else if (zero_cnt_q == ZERO_LAST) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else begin
            zero_cnt_d = zero_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Payload is not checked; only RESYNC or reset leaves this state.
        end
        default: begin
          state_d  = ST_FLUSH;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters and output registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FLUSH;
      flush_cnt_q  <= '0;
      zero_cnt_q   <= '0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      err_cnt_q    <= err_cnt_d;
      locked_q     <= locked_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign locked_o     = locked_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_xor_lfsr_descrambler.sv
// Directed bench for xor_lfsr_descrambler: a bench-side x^7 + x^6 + 1
// scrambler feeds the line, expected values are hand-derived per bit index.
module tb_xor_lfsr_descrambler;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       resync;
  logic       dout;
  logic       dout_valid;
  logic       locked;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Far-end scrambler state; scr_q[0] is the newest transmitted bit.
  logic [6:0] scr_q;

  xor_lfsr_descrambler #(
    .WIDTH      (7),
    .TAP        (6),
    .LOCK_COUNT (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .resync_i     (resync),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .locked_o     (locked),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic b, input logic v, input logic rs);
    din       = b;
    din_valid = v;
    resync    = rs;
    @(posedge clk);
    #1;
    din       = 1'b0;
    din_valid = 1'b0;
    resync    = 1'b0;
  endtask

  // Scramble one data bit and put it on the line, optionally corrupted.
  task automatic send(input logic d, input logic flip, input logic rs);
    logic s;
    s     = d ^ scr_q[5] ^ scr_q[6];
    scr_q = {scr_q[5:0], s};
    step(s ^ flip, 1'b1, rs);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    resync    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] payload;
    int         exp_err;
    int         gap;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("idle_dout", dout, 0);
      check("idle_dout_valid", dout_valid, 0);
      check("idle_locked", locked, 0);
      check("idle_err_cnt", err_cnt, 0);
    end

    // Clean training: 30 scrambled zeros, lock after bit 23.
    scr_q = 7'h7F;
    for (int i = 1; i <= 30; i++) begin
      send(1'b0, 1'b0, 1'b0);
      check("clean_dout_valid", dout_valid, 1);
      if (i >= 8) check("clean_dout", dout, 0);
      check("clean_locked", locked, (i >= 23) ? 1 : 0);
      check("clean_err_cnt", err_cnt, 0);
    end

    // Error in TRAIN: line bit 15 flipped gives ones at bits 15, 21 and 22;
    // lock then needs bits 23..38 clean.
    do_reset();
    scr_q = 7'h7F;
    for (int i = 1; i <= 40; i++) begin
      send(1'b0, (i == 15), 1'b0);
      if (i >= 8) check("err_dout", dout, (i == 15 || i == 21 || i == 22) ? 1 : 0);
      exp_err = (i < 15) ? 0 : (i < 21) ? 1 : (i == 21) ? 2 : 3;
      check("err_err_cnt", err_cnt, exp_err);
      check("err_locked", locked, (i >= 38) ? 1 : 0);
    end

    // Payload 0xA5 MSB first after lock.
    payload = 8'hA5;
    for (int k = 7; k >= 0; k--) begin
      send(payload[k], 1'b0, 1'b0);
      check("pay_dout", dout, payload[k]);
      check("pay_dout_valid", dout_valid, 1);
      check("pay_err_cnt", err_cnt, 3);
      check("pay_locked", locked, 1);
    end

    // Idle gap: DOUT holds its last value, DOUT_VALID low.
    step(1'b0, 1'b0, 1'b0);
    check("gap_dout_valid", dout_valid, 0);
    check("gap_dout_hold", dout, 1);
    check("gap_locked", locked, 1);

    // RESYNC with a valid bit while locked.
    send(1'b1, 1'b0, 1'b1);
    check("rs_locked", locked, 0);
    check("rs_dout", dout, 1);
    check("rs_dout_valid", dout_valid, 1);
    check("rs_err_cnt", err_cnt, 3);
    for (int i = 1; i <= 23; i++) begin
      send(1'b0, 1'b0, 1'b0);
      check("relock_dout", dout, 0);
      check("relock_locked", locked, (i == 23) ? 1 : 0);
      check("relock_err_cnt", err_cnt, 3);
    end

    // RESYNC without a valid bit.
    step(1'b1, 1'b0, 1'b1);
    check("rs_idle_locked", locked, 0);
    check("rs_idle_dout_valid", dout_valid, 0);
    check("rs_idle_dout_hold", dout, 0);
    check("rs_idle_err_cnt", err_cnt, 3);

    // Reset asserted mid-stream clears everything immediately.
    din       = 1'b1;
    din_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_dout", dout, 0);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Saturation: flush, then 300 descrambled ones with random gaps.
    scr_q = 7'h7F;
    for (int i = 1; i <= 7; i++) send(1'b1, 1'b0, 1'b0);
    check("sat_flush_err_cnt", err_cnt, 0);
    for (int i = 1; i <= 300; i++) begin
      send(1'b1, 1'b0, 1'b0);
      check("sat_dout", dout, 1);
      check("sat_err_cnt", err_cnt, (i > 255) ? 255 : i);
      check("sat_locked", locked, 0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'b0);
        check("sat_gap_dout_valid", dout_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_lfsr_descrambler.md
# xor_lfsr_descrambler

Self-synchronising serial descrambler: the receive-side counterpart of an XOR/LFSR scrambler built from 74x86 XOR gates and a 74x164-style shift register. It undoes the scrambling polynomial x^7 + x^6 + 1 on a 1-bit stream, then tracks link training by counting descrambled zero bits. It sits between the serial line input and the byte deserialiser.

## Interface
Parameters:
- WIDTH, 7: shift register length, equal to the polynomial degree.
- TAP, 6: inner tap position (1-based), 1 ≤ TAP < WIDTH.
- LOCK_COUNT, 16: consecutive descrambled zeros required in TRAIN to declare lock, range 1..255.

Ports:
- CLK  in  1  rising-edge clock.
- RST_n  in  1  asynchronous, active-low reset.
- DIN  in  1  scrambled serial bit.
- DIN_VALID  in  1  DIN qualifies this cycle.
- RESYNC  in  1  single-cycle request to restart training.
- DOUT  out  1  descrambled bit (registered).
- DOUT_VALID  out  1  DOUT qualifies this cycle.
- LOCKED  out  1  training complete.
- ERR_CNT  out  8  saturating count of training errors.

## Operation
- Shift register SR[1..WIDTH]. SR[1] holds the newest bit. On a valid cycle, SR shifts toward WIDTH and DIN enters SR[1].
- Descramble on each valid cycle: DOUT ← DIN ^ SR[TAP] ^ SR[WIDTH], using SR values from before the shift.
- The state machine changes only on valid cycles, except for RESYNC:
  - FLUSH: a flush counter counts valid bits. On the WIDTH-th valid bit, go to TRAIN and clear the zero counter. DOUT is produced in FLUSH but is not checked.
  - TRAIN: if the descrambled bit is 0, increment the zero counter. When the counter reaches LOCK_COUNT, go to LOCKED. If the bit is 1, clear the zero counter and increment ERR_CNT, saturating at 255.
  - LOCKED: payload passes through unchecked. ERR_CNT holds. Only RESYNC or reset leaves this state.
- RESYNC in any state:
  - State goes to FLUSH, and the flush and zero counters clear.
  - LOCKED drops.
  - ERR_CNT and SR are preserved.
- RESYNC together with DIN_VALID in the same cycle: the bit is still shifted and descrambled with normal DOUT/DOUT_VALID. The state goes to FLUSH, and that bit does not count toward the new flush.
- If DIN_VALID is low, SR, the counters, DOUT and the state hold. DOUT_VALID goes low.

## Timing
- Reset values, all asynchronous on the fall of RST_n:
  - SR = 0, state FLUSH, all counters 0.
  - DOUT = 0, DOUT_VALID = 0, LOCKED = 0, ERR_CNT = 0.
- Latency: DIN is sampled at edge N. DOUT and DOUT_VALID are valid after edge N, for exactly one cycle per valid input.
- LOCKED:
  - Rises after the edge that samples the LOCK_COUNT-th consecutive zero in TRAIN.
  - With a continuous valid stream from reset, that is after valid bit WIDTH + LOCK_COUNT (23 with defaults).
  - Falls after the edge that samples RESYNC.
- Back-to-back DIN_VALID sustains one bit per clock. Gaps of any length are allowed.
- Reset deasserting mid-stream restarts at FLUSH. No partial state survives the reset.

## Structure
- Shared package holds:
  - the state encoding constants (FLUSH, TRAIN, LOCKED);
  - the default polynomial constants (WIDTH 7, TAP 6);
  - ERR_CNT width 8 and its saturation value 255.
- Sub-module `shift_reg_n` is a parameterised serial-in/parallel-out register with enable and async active-low clear, 74x164 style. The descrambler instantiates it once. The XOR, state machine and counters live in the top module.

## Test plan
- Reset then idle: hold RST_n low, then release with DIN_VALID = 0 for 10 cycles → DOUT = 0, DOUT_VALID = 0, LOCKED = 0, ERR_CNT = 0 throughout.
- Clean training: the bench scrambler (seed 7'h7F) scrambles 30 zero bits, sent back-to-back → LOCKED rises after the 23rd valid bit; all DOUT from bit 8 onward are 0; ERR_CNT = 0.
- Error in TRAIN: flip scrambled bit 15 → ERR_CNT = 1, the zero counter restarts, and LOCKED is delayed until 16 further clean zeros. Each scrambler self-sync error yields three 1s, so ERR_CNT ends at 3.
- Payload: after lock, scramble 0xA5 sent MSB first → DOUT reproduces 1,0,1,0,0,1,0,1 with a one-cycle lag; ERR_CNT unchanged.
- RESYNC with DIN_VALID while LOCKED → LOCKED = 0 next cycle, the bit is still descrambled, ERR_CNT preserved, and relock needs 23 more valid bits.
- Saturation and gaps: force 300 training errors with random DIN_VALID gaps → ERR_CNT stops at 255, and no DOUT_VALID appears during gaps.
